// File: rtl/power_xor_pipe_monitor_if.sv
// Operand/result stream bundle for power_xor_pipe_monitor.
// The master modport is the producer/consumer side; the slave modport is the pipeline.
interface power_xor_pipe_monitor_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_c;
  logic [WIDTH-1:0] in_d;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;

  modport master (
    output in_valid, in_a, in_b, in_c, in_d, out_ready,
    input  in_ready, out_valid, out_y
  );

  modport slave (
    input  in_valid, in_a, in_b, in_c, in_d, out_ready,
    output in_ready, out_valid, out_y
  );
endinterface

// File: rtl/power_xor_pipe_monitor.sv
// Two-stage y = (b & (c ^ d)) ^ (~a & b) pipeline with a windowed output toggle monitor.
// Define POWER_INPUT_TOGGLE_EN to also count input operand toggles (in_toggle_count).
//
// state   | meaning
// IDLE    | no window; toggle_count holds last result
// MEASURE | accumulating toggles of accepted output beats
// DONE    | window complete, win_done pulses for one cycle
module power_xor_pipe_monitor #(
  parameter int WIDTH  = 8,
  parameter int WINDOW = 256,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  power_xor_pipe_monitor_if.slave bus,
  input  logic                    win_start,
  output logic                    win_busy,
  output logic                    win_done,
  output logic [CNT_W-1:0]        toggle_count,
  output logic                    toggle_sat
`ifdef POWER_INPUT_TOGGLE_EN
  ,
  output logic [CNT_W-1:0]        in_toggle_count
`endif
);

  localparam int POP_W  = $clog2(WIDTH + 1);
  localparam int SUM_W  = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
  localparam int BEAT_W = $clog2(WINDOW + 1);
  localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

  typedef enum logic [1:0] {IDLE, MEASURE, DONE} state_t;

  state_t state, state_nxt;

  logic             s1_valid, s2_valid;
  logic [WIDTH-1:0] t_r, u_r, y_r, prev_y;
  logic             s1_load, s2_load, accept, out_hs;
  logic [BEAT_W-1:0] beat_cnt;
  logic             win_clr, meas, last_beat;
  logic [POP_W-1:0] out_pop;
  logic [SUM_W-1:0] out_sum;

  // S1 may refill in the same cycle it drains, so in_ready depends on out_ready.
  assign s2_load  = ~s2_valid | bus.out_ready;
  assign s1_load  = ~s1_valid | s2_load;
  assign accept   = bus.in_valid & s1_load;
  assign out_hs   = s2_valid & bus.out_ready;

  assign bus.in_ready  = s1_load;
  assign bus.out_valid = s2_valid;
  assign bus.out_y     = y_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      t_r      <= '0;
      u_r      <= '0;
      y_r      <= '0;
      prev_y   <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= accept;
        if (accept) begin
          t_r <= bus.in_b & (bus.in_c ^ bus.in_d);
          u_r <= ~bus.in_a & bus.in_b;
        end
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) y_r <= t_r ^ u_r;
      end
      if (out_hs) prev_y <= y_r;
    end
  end

  assign out_pop   = POP_W'($countones(y_r ^ prev_y));
  assign out_sum   = SUM_W'(toggle_count) + SUM_W'(out_pop);
  assign last_beat = (beat_cnt == BEAT_W'(WINDOW - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    win_busy  = 1'b0;
    win_done  = 1'b0;
    win_clr   = 1'b0;
    meas      = 1'b0;
    case (state)
      IDLE: begin
        if (win_start) begin
          state_nxt = MEASURE;
          win_clr   = 1'b1;
        end
      end
      MEASURE: begin
        win_busy = 1'b1;
        meas     = 1'b1;
        if (out_hs && last_beat) state_nxt = DONE;
      end
      DONE: begin
        win_done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef POWER_INPUT_TOGGLE_EN
  localparam int IN_W      = 4 * WIDTH;
  localparam int IN_POP_W  = $clog2(IN_W + 1);
  localparam int IN_SUM_W  = ((CNT_W > IN_POP_W) ? CNT_W : IN_POP_W) + 1;
  localparam logic [IN_SUM_W-1:0] IN_MAX = {{(IN_SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

  logic [IN_W-1:0]     prev_in, cur_in;
  logic [IN_SUM_W-1:0] in_sum;

  assign cur_in = {bus.in_a, bus.in_b, bus.in_c, bus.in_d};
  assign in_sum = IN_SUM_W'(in_toggle_count) + IN_SUM_W'($countones(cur_in ^ prev_in));

  always_ff @(posedge clk) begin
    if (rst)         prev_in <= '0;
    else if (accept) prev_in <= cur_in;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst || win_clr) begin
      toggle_count <= '0;
      toggle_sat   <= 1'b0;
      beat_cnt     <= '0;
`ifdef POWER_INPUT_TOGGLE_EN
      in_toggle_count <= '0;
`endif
    end else begin
      if (meas && out_hs) begin
        beat_cnt <= beat_cnt + BEAT_W'(1);
        if (out_sum > CNT_MAX) begin
          toggle_count <= {CNT_W{1'b1}};
          toggle_sat   <= 1'b1;
        end else begin
          toggle_count <= out_sum[CNT_W-1:0];
        end
      end
`ifdef POWER_INPUT_TOGGLE_EN
      if (meas && accept) begin
        if (in_sum > IN_MAX) begin
          in_toggle_count <= {CNT_W{1'b1}};
          toggle_sat      <= 1'b1;
        end else begin
          in_toggle_count <= in_sum[CNT_W-1:0];
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_power_xor_pipe_monitor.sv
// Directed bench: a 16-bit-counter instance and a 4-bit-counter instance share one stimulus stream.
module tb_power_xor_pipe_monitor;
  logic clk = 1'b0;
  logic rst;
  logic win_start;
  logic busy_m, done_m, sat_m, busy_s, done_s, sat_s;
  logic [15:0] cnt_m;
  logic [3:0]  cnt_s;
`ifdef POWER_INPUT_TOGGLE_EN
  logic [15:0] icnt_m;
  logic [3:0]  icnt_s;
`endif
  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  power_xor_pipe_monitor_if #(.WIDTH(8)) bus ();
  power_xor_pipe_monitor_if #(.WIDTH(8)) bus_s ();

  assign bus_s.in_valid  = bus.in_valid;
  assign bus_s.in_a      = bus.in_a;
  assign bus_s.in_b      = bus.in_b;
  assign bus_s.in_c      = bus.in_c;
  assign bus_s.in_d      = bus.in_d;
  assign bus_s.out_ready = bus.out_ready;

  power_xor_pipe_monitor #(.WIDTH(8), .WINDOW(4), .CNT_W(16)) dut_m (
    .clk(clk), .rst(rst), .bus(bus.slave), .win_start(win_start),
    .win_busy(busy_m), .win_done(done_m), .toggle_count(cnt_m), .toggle_sat(sat_m)
`ifdef POWER_INPUT_TOGGLE_EN
    , .in_toggle_count(icnt_m)
`endif
  );

  power_xor_pipe_monitor #(.WIDTH(8), .WINDOW(4), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .bus(bus_s.slave), .win_start(win_start),
    .win_busy(busy_s), .win_done(done_s), .toggle_count(cnt_s), .toggle_sat(sat_s)
`ifdef POWER_INPUT_TOGGLE_EN
    , .in_toggle_count(icnt_s)
`endif
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] a, b, c, d);
    bus.in_valid = v;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_c = c;
    bus.in_d = d;
  endtask

  // y=F0, y=0F, y=C3, y=00 operand sets
  task automatic beat_f0(); drive(1'b1, 8'h00, 8'hFF, 8'h0F, 8'h00); endtask
  task automatic beat_0f(); drive(1'b1, 8'h00, 8'hFF, 8'hF0, 8'h00); endtask
  task automatic beat_c3(); drive(1'b1, 8'h00, 8'hFF, 8'h3C, 8'h00); endtask
  task automatic beat_00(); drive(1'b1, 8'hFF, 8'hAA, 8'h00, 8'h00); endtask
  task automatic idle_in(); drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00); endtask

  task automatic do_reset();
    rst = 1'b1;
    win_start = 1'b0;
    idle_in();
    bus.out_ready = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    win_start = 1'b0;
    idle_in();
    bus.out_ready = 1'b1;
    cycle();
    cycle();
    total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", bus.out_valid); else passed++;
    total++; if (bus.out_y !== 8'h00) $display("FAIL rst_out_y got %h exp 00", bus.out_y); else passed++;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready got %b exp 1", bus.in_ready); else passed++;
    total++; if (busy_m !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy_m); else passed++;
    total++; if (done_m !== 1'b0) $display("FAIL rst_done got %b exp 0", done_m); else passed++;
    total++; if (cnt_m !== 16'd0) $display("FAIL rst_count got %0d exp 0", cnt_m); else passed++;
    total++; if (sat_m !== 1'b0) $display("FAIL rst_sat got %b exp 0", sat_m); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_function();
    beat_f0();
    cycle();
    total++; if (bus.out_valid !== 1'b0) $display("FAIL fn_latency got valid %b exp 0", bus.out_valid); else passed++;
    drive(1'b1, 8'hFF, 8'hAA, 8'h00, 8'h00);
    cycle();
    total++; if (bus.out_valid !== 1'b1) $display("FAIL fn_valid1 got %b exp 1", bus.out_valid); else passed++;
    total++; if (bus.out_y !== 8'hF0) $display("FAIL fn_y1 got %h exp F0", bus.out_y); else passed++;
    drive(1'b1, 8'h00, 8'hAA, 8'hFF, 8'h00);
    cycle();
    total++; if (bus.out_y !== 8'h00) $display("FAIL fn_y2 got %h exp 00", bus.out_y); else passed++;
    idle_in();
    cycle();
    total++; if (bus.out_valid !== 1'b1) $display("FAIL fn_valid3 got %b exp 1", bus.out_valid); else passed++;
    total++; if (bus.out_y !== 8'h00) $display("FAIL fn_y3 got %h exp 00", bus.out_y); else passed++;
    cycle();
    total++; if (bus.out_valid !== 1'b0) $display("FAIL fn_drain got %b exp 0", bus.out_valid); else passed++;
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    beat_f0();
    #1;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL bp_ready_a got %b exp 1", bus.in_ready); else passed++;
    cycle();
    beat_0f();
    #1;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL bp_ready_b got %b exp 1", bus.in_ready); else passed++;
    cycle();
    beat_c3();
    #1;
    total++; if (bus.in_ready !== 1'b0) $display("FAIL bp_ready_full got %b exp 0", bus.in_ready); else passed++;
    total++; if (bus.out_y !== 8'hF0) $display("FAIL bp_y_first got %h exp F0", bus.out_y); else passed++;
    cycle();
    total++; if (bus.in_ready !== 1'b0) $display("FAIL bp_ready_hold got %b exp 0", bus.in_ready); else passed++;
    total++; if (bus.out_y !== 8'hF0 || bus.out_valid !== 1'b1) $display("FAIL bp_y_hold got %h/%b exp F0/1", bus.out_y, bus.out_valid); else passed++;
    bus.out_ready = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL bp_ready_release got %b exp 1", bus.in_ready); else passed++;
    cycle();
    idle_in();
    total++; if (bus.out_y !== 8'h0F) $display("FAIL bp_y_second got %h exp 0F", bus.out_y); else passed++;
    cycle();
    total++; if (bus.out_y !== 8'hC3 || bus.out_valid !== 1'b1) $display("FAIL bp_y_third got %h/%b exp C3/1", bus.out_y, bus.out_valid); else passed++;
    cycle();
    total++; if (bus.out_valid !== 1'b0) $display("FAIL bp_empty got %b exp 0", bus.out_valid); else passed++;
  endtask

  task automatic test_window();
    do_reset();
    win_start = 1'b1;
    cycle();
    win_start = 1'b0;
    total++; if (busy_m !== 1'b1) $display("FAIL win_busy_start got %b exp 1", busy_m); else passed++;
    for (int i = 1; i <= 8; i++) begin
      if (i <= 4) begin
        if (i % 2 == 1) beat_f0(); else beat_00();
      end else begin
        idle_in();
      end
      cycle();
      total++; if (done_m !== (i == 6)) $display("FAIL win_done_%0d got %b exp %b", i, done_m, (i == 6)); else passed++;
      total++; if (busy_m !== (i <= 5)) $display("FAIL win_busy_%0d got %b exp %b", i, busy_m, (i <= 5)); else passed++;
    end
    total++; if (cnt_m !== 16'd16) $display("FAIL win_count got %0d exp 16", cnt_m); else passed++;
    total++; if (sat_m !== 1'b0) $display("FAIL win_sat got %b exp 0", sat_m); else passed++;
    total++; if (cnt_s !== 4'd15) $display("FAIL sat_count got %0d exp 15", cnt_s); else passed++;
    total++; if (sat_s !== 1'b1) $display("FAIL sat_flag got %b exp 1", sat_s); else passed++;
  endtask

  task automatic test_sat_clear();
    win_start = 1'b1;
    cycle();
    win_start = 1'b0;
    total++; if (cnt_s !== 4'd0) $display("FAIL clr_count got %0d exp 0", cnt_s); else passed++;
    total++; if (sat_s !== 1'b0) $display("FAIL clr_sat got %b exp 0", sat_s); else passed++;
    total++; if (cnt_m !== 16'd0) $display("FAIL clr_count_m got %0d exp 0", cnt_m); else passed++;
  endtask

  task automatic test_reset_mid_window();
    beat_f0();
    cycle();
    beat_0f();
    cycle();
    beat_c3();
    cycle();
    idle_in();
    cycle();
    total++; if (cnt_m !== 16'd12) $display("FAIL mid_count got %0d exp 12", cnt_m); else passed++;
    total++; if (cnt_s !== 4'd12 || sat_s !== 1'b0) $display("FAIL mid_count_s got %0d/%b exp 12/0", cnt_s, sat_s); else passed++;
    total++; if (bus.out_y !== 8'hC3 || bus.out_valid !== 1'b1) $display("FAIL mid_inflight got %h/%b exp C3/1", bus.out_y, bus.out_valid); else passed++;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    total++; if (bus.out_valid !== 1'b0 || bus.out_y !== 8'h00) $display("FAIL mid_rst_out got %h/%b exp 00/0", bus.out_y, bus.out_valid); else passed++;
    total++; if (busy_m !== 1'b0 || cnt_m !== 16'd0) $display("FAIL mid_rst_win got %b/%0d exp 0/0", busy_m, cnt_m); else passed++;
    win_start = 1'b1;
    cycle();
    win_start = 1'b0;
    beat_0f();
    cycle();
    idle_in();
    cycle();
    cycle();
    total++; if (cnt_m !== 16'd4) $display("FAIL new_win_count got %0d exp 4", cnt_m); else passed++;
    total++; if (busy_m !== 1'b1) $display("FAIL new_win_busy got %b exp 1", busy_m); else passed++;
  endtask

`ifdef POWER_INPUT_TOGGLE_EN
  task automatic test_input_toggle();
    do_reset();
    win_start = 1'b1;
    cycle();
    win_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) drive(1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
      else            drive(1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
      cycle();
    end
    idle_in();
    total++; if (icnt_m !== 16'd96) $display("FAIL in_tog_count got %0d exp 96", icnt_m); else passed++;
    total++; if (icnt_s !== 4'd15 || sat_s !== 1'b1) $display("FAIL in_tog_sat got %0d/%b exp 15/1", icnt_s, sat_s); else passed++;
  endtask
`endif

  initial begin
    rst = 1'b1;
    win_start = 1'b0;
    bus.out_ready = 1'b1;
    idle_in();
    test_reset();
    test_function();
    test_backpressure();
    test_window();
    test_sat_clear();
    test_reset_mid_window();
`ifdef POWER_INPUT_TOGGLE_EN
    test_input_toggle();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
